// File: rtl/fifo_generic_v2.sv
// -----------------------------------------------------------------------------
// fifo_generic_v2
//
// Single-clock parametrised FIFO. Successor to fifo_generic: same write/read
// and flag interface, plus non-power-of-two depth, an occupancy count, a
// synchronous flush and registered overflow/underflow error pulses.
//
// Build option:
//   FIFO_FWFT_EN defined   : first-word-fall-through, read_data is the head
//                            word shown combinationally from storage.
//   FIFO_FWFT_EN undefined : registered read_data, valid the cycle after an
//                            accepted read (fifo_generic timing).
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   clk_enable    state advances only while high
//   flush         synchronous clear of pointers and count
//   write         push request, data on write_data
//   read          pop request
//   write_data    push data
//   read_data     pop data (registered or FWFT, see above)
//   empty, full   count == 0 / count == FIFO_DEPTH
//   almost_empty  count <= ALMOSTEMPTY_DEPTH
//   almost_full   count >= FIFO_DEPTH - ALMOSTFULL_DEPTH
//   count         current occupancy
//   overflow      one-cycle pulse after a refused write
//   underflow     one-cycle pulse after a refused read
// -----------------------------------------------------------------------------
module fifo_generic_v2 #(
    parameter int FIFO_DEPTH        = 8,
    parameter int FIFO_DATA_WIDTH   = 8,
    parameter int ALMOSTFULL_DEPTH  = 3,
    parameter int ALMOSTEMPTY_DEPTH = 3,
    localparam int CW = $clog2(FIFO_DEPTH + 1),
    localparam int PW = $clog2(FIFO_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_enable,
    input  logic                       flush,
    input  logic                       write,
    input  logic                       read,
    input  logic [FIFO_DATA_WIDTH-1:0] write_data,
    output logic [FIFO_DATA_WIDTH-1:0] read_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [CW-1:0]              count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOSTEMPTY_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(FIFO_DEPTH - ALMOSTFULL_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

    // Depth need not be a power of two, so wrap by compare, not truncation.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    logic [FIFO_DATA_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count_q;

    logic active;
    logic rd_acc;
    logic wr_acc;
    logic ovf_req;
    logic unf_req;

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);

    // Flush outranks both requests and suppresses their error pulses.
    assign active  = clk_enable && !flush;
    assign rd_acc  = active && read && !empty;
    // A read in the same edge frees a slot, so a write at full still fits.
    assign wr_acc  = active && write && (!full || rd_acc);
    assign ovf_req = active && write && !wr_acc;
    assign unf_req = active && read && !rd_acc;

    // Storage carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clk_enable) begin
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
                if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
                case ({wr_acc, rd_acc})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Error pulses are sampled every edge (not gated by clk_enable) so they
    // last exactly one cycle and fall to zero while the block is disabled.
    logic overflow_p1;
    logic underflow_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_p1  <= 1'b0;
            underflow_p1 <= 1'b0;
        end else begin
            overflow_p1  <= ovf_req;
            underflow_p1 <= unf_req;
        end
    end

    assign overflow  = overflow_p1;
    assign underflow = underflow_p1;

`ifdef FIFO_FWFT_EN
    // Head word is visible directly; undefined content while empty.
    assign read_data = mem[rd_ptr];
`else
    // Output stage: captures the head word on the edge that accepts a read.
    logic [FIFO_DATA_WIDTH-1:0] read_data_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_p1 <= '0;
        end else if (rd_acc) begin
            read_data_p1 <= mem[rd_ptr];
        end
    end

    assign read_data = read_data_p1;
`endif

endmodule

// File: doc/fifo_generic_v2.md
# fifo_generic_v2

Parametrised synchronous FIFO that succeeds `fifo_generic`: same write/read/flag interface plus non-power-of-two depth, an occupancy count, synchronous flush, and registered overflow/underflow error pulses. Sits between producer and consumer logic in one clock domain, gated by `clk_enable`. A compile-time macro selects first-word-fall-through (FWFT) or registered-read output.

## Interface
- `FIFO_DEPTH`, 8: number of entries; any integer >= 2, not restricted to powers of two.
- `FIFO_DATA_WIDTH`, 8: word width in bits.
- `ALMOSTFULL_DEPTH`, 3: `almost_full` asserts when free slots <= this value; range 1..FIFO_DEPTH-1.
- `ALMOSTEMPTY_DEPTH`, 3: `almost_empty` asserts when count <= this value; range 1..FIFO_DEPTH-1.
- `CW` (localparam): $clog2(FIFO_DEPTH+1).

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clk_enable`  in  1  state advances only when high.
- `flush`  in  1  synchronous clear of contents.
- `write`  in  1  push request.
- `read`  in  1  pop request.
- `write_data`  in  FIFO_DATA_WIDTH  push data.
- `read_data`  out  FIFO_DATA_WIDTH  pop data; see Configuration.
- `empty`  out  1  count == 0.
- `full`  out  1  count == FIFO_DEPTH.
- `almost_empty`  out  1  count <= ALMOSTEMPTY_DEPTH.
- `almost_full`  out  1  count >= FIFO_DEPTH - ALMOSTFULL_DEPTH.
- `count`  out  CW  current occupancy.
- `overflow`  out  1  one-cycle pulse: write refused.
- `underflow`  out  1  one-cycle pulse: read refused.

## Operation
- Storage: FIFO_DEPTH x FIFO_DATA_WIDTH register array; write pointer, read pointer, and `count` registers.
- Pointers increment modulo FIFO_DEPTH: value FIFO_DEPTH-1 wraps to 0 (explicit compare, not bit truncation).
- Per enabled edge, priority: `flush`, then read/write acceptance.
- `flush`: pointers and count <= 0; write/read ignored; no error pulse; storage and registered `read_data` unchanged.
- Read accepted iff `read` && !`empty`. Write accepted iff `write` && (!`full` || read accepted).
- Read while empty: no state change, `underflow` pulses, even if a write is accepted the same cycle (the write is accepted; count becomes 1).
- Write while full with no accepted read: data dropped, `overflow` pulses.
- Write and read both accepted: count unchanged; at full the freed slot takes the new word.
- Flags and `count` are combinational from the `count` register; no extra latency.
- `clk_enable` low: all registers hold; write/read/flush ignored; error outputs drop to 0.

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0, `read_data`=0, pointers=0.
- Flags, `count` update on the edge that accepts the operation.
- Registered-read mode: `read_data` updates one edge after an accepted read (data available the cycle after the read strobe); holds otherwise.
- FWFT mode: `read_data` shows the head word combinationally while !`empty`; accepted read advances to the next word after the edge; value while empty is don't-care.
- Write-to-read latency in FWFT: word visible the cycle after the write edge.
- `overflow`/`underflow` registered: asserted one cycle after the offending request edge, for exactly one cycle per refused request.
- Reset asserted mid-operation clears everything immediately, independent of `clk`; contents are lost.

## Configuration
- `FIFO_FWFT_EN` defined: first-word-fall-through output, combinational from storage at the read pointer.
- `FIFO_FWFT_EN` undefined: registered `read_data`, one-cycle read latency, compatible with `fifo_generic` timing.
- All other behaviour is identical in both builds.

## Test plan
- Reset then write 0..9 on alternate cycles (depth 8) -> words 0..7 accepted, `almost_full` asserts at count 5, `full` at count 8, `overflow` pulses for writes 8 and 9, `count`=8.
- From full, 10 alternate reads -> `read_data` 0..7 in order (a cycle later without FWFT), `almost_empty` at count 3, `empty` after 8th, `underflow` pulses on reads 9 and 10.
- FIFO_DEPTH=5: write/read 12 words interleaved -> pointers wrap 4->0, data order preserved, `count` never exceeds 5.
- At full, simultaneous write 0xAA and read -> head returned, `count` stays 8, no `overflow`, 0xAA read out last.
- Load 4 words, assert `flush` together with `write` -> `count`=0, `empty`=1, no pulse; `clk_enable`=0 with write/read -> no change.
- Async `reset` asserted between edges with count 6 -> all outputs return to reset values before the next edge.
